// File: rtl/bht_if.sv
// rtl/bht_if.sv - predict/resolve bus between the fetch model and bht_ctrl
interface bht_if #(
    parameter int IDX_W = 4,
    parameter int DEPTH = 4
);
    logic                     pred_valid;
    logic [IDX_W-1:0]         pred_pc;
    logic                     pred_ready;
    logic                     prediction;
    logic                     res_valid;
    logic                     res_taken;
    logic                     mispredict;
    logic                     res_err;
    logic                     busy;
    logic [$clog2(DEPTH):0]   occupancy;

    modport slave (
        input  pred_valid, pred_pc, res_valid, res_taken,
        output pred_ready, prediction, mispredict, res_err, busy, occupancy
    );

    modport master (
        output pred_valid, pred_pc, res_valid, res_taken,
        input  pred_ready, prediction, mispredict, res_err, busy, occupancy
    );
endinterface

// File: rtl/bht_ctrl.sv
// rtl/bht_ctrl.sv - gshare branch history table with in-order in-flight queue
module bht_ctrl #(
    parameter int IDX_W  = 4,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic  clk,
    input  logic  reset,
    bht_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int TBL   = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_HALF = CTR_W'(1) << (CTR_W - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t             state;
    logic [IDX_W-1:0]   init_ptr;
    logic [CTR_W-1:0]   ctr [TBL];
    logic [IDX_W-1:0]   q_idx [DEPTH];
    logic               q_pred [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [OCC_W-1:0]   count;
    logic [HIST_W-1:0]  spec_hist;
    logic [HIST_W-1:0]  commit_hist;
    logic               res_err_q;

    logic [IDX_W-1:0]   lookup_idx;
    logic [IDX_W-1:0]   head_idx;
    logic [CTR_W-1:0]   head_ctr;
    logic [CTR_W-1:0]   ctr_next;
    logic [HIST_W-1:0]  commit_next;
    logic [HIST_W-1:0]  spec_shift;
    logic               empty;
    logic               full;
    logic               pred_fire;
    logic               res_fire;
    logic               misp;

    assign lookup_idx  = bus.pred_pc ^ IDX_W'(spec_hist);
    assign head_idx    = q_idx[head];
    assign head_ctr    = ctr[head_idx];
    assign empty       = (count == '0);
    assign full        = (count == OCC_W'(DEPTH));
    assign commit_next = HIST_W'({commit_hist, bus.res_taken});
    assign spec_shift  = HIST_W'({spec_hist, bus.prediction});

    assign bus.prediction = (ctr[lookup_idx] >= CTR_HALF);
    assign bus.pred_ready = (state == RUN) && !full;
    assign bus.busy       = (state == INIT);
    assign bus.occupancy  = count;
    assign bus.res_err    = res_err_q;

    assign pred_fire = bus.pred_valid && bus.pred_ready;
    assign res_fire  = (state == RUN) && bus.res_valid && !empty;
    assign misp      = res_fire && (bus.res_taken != q_pred[head]);
    assign bus.mispredict = misp;

    // Saturating update: the counter never wraps in either direction.
    always_comb begin
        ctr_next = head_ctr;
        if (bus.res_taken) begin
            if (head_ctr != CTR_MAX) ctr_next = head_ctr + CTR_W'(1);
        end else begin
            if (head_ctr != '0) ctr_next = head_ctr - CTR_W'(1);
        end
    end

    // Table contents are undefined until INIT has swept every entry.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            ctr[init_ptr] <= '0;
        end else if (res_fire) begin
            ctr[head_idx] <= ctr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (pred_fire) begin
            q_idx[tail]  <= lookup_idx;
            q_pred[tail] <= bus.prediction;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= INIT;
            init_ptr    <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            spec_hist   <= '0;
            commit_hist <= '0;
            res_err_q   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    res_err_q <= 1'b0;
                    init_ptr  <= init_ptr + IDX_W'(1);
                    if (init_ptr == '1) state <= RUN;
                end
                RUN: begin
                    res_err_q <= bus.res_valid && empty;
                    if (res_fire) commit_hist <= commit_next;
                    // A mispredict also drops a predict accepted in the same cycle.
                    if (misp) begin
                        head      <= '0;
                        tail      <= '0;
                        count     <= '0;
                        spec_hist <= commit_next;
                    end else begin
                        if (pred_fire) begin
                            tail      <= tail + PTR_W'(1);
                            spec_hist <= spec_shift;
                        end
                        if (res_fire) head <= head + PTR_W'(1);
                        count <= count + OCC_W'(pred_fire) - OCC_W'(res_fire);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_bht_ctrl.sv
// tb/tb_bht_ctrl.sv - directed vector bench for bht_ctrl
module tb_bht_ctrl;
    logic clk;
    logic reset;

    bht_if #(.IDX_W(4), .DEPTH(4)) bus ();

    bht_ctrl #(.IDX_W(4), .CTR_W(2), .HIST_W(4), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       pv;
        logic [3:0] pc;
        logic       rv;
        logic       rt;
        logic       ep;
        logic       em;
        logic       er;
        int         eo;
        logic       ee;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   seg_b;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic add(input logic pv, input int pc, input logic rv, input logic rt,
                       input logic ep, input logic em, input logic er, input int eo,
                       input logic ee);
        vec_t v;
        v.pv = pv; v.pc = 4'(pc); v.rv = rv; v.rt = rt;
        v.ep = ep; v.em = em; v.er = er; v.eo = eo; v.ee = ee;
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            bus.pred_valid = vecs[i].pv;
            bus.pred_pc    = vecs[i].pc;
            bus.res_valid  = vecs[i].rv;
            bus.res_taken  = vecs[i].rt;
            #1;
            chk($sformatf("v%0d_prediction", i), int'(bus.prediction), int'(vecs[i].ep));
            chk($sformatf("v%0d_mispredict", i), int'(bus.mispredict), int'(vecs[i].em));
            chk($sformatf("v%0d_pred_ready", i), int'(bus.pred_ready), int'(vecs[i].er));
            chk($sformatf("v%0d_occupancy", i),  int'(bus.occupancy),  vecs[i].eo);
            chk($sformatf("v%0d_res_err", i),    int'(bus.res_err),    int'(vecs[i].ee));
        end
        bus.pred_valid = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
    endtask

    // Resolves are held high during INIT; they must be ignored without res_err.
    task automatic init_run(input int n, input bit expect_run);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("init%0d_busy", i),    int'(bus.busy),       1);
            chk($sformatf("init%0d_ready", i),   int'(bus.pred_ready), 0);
            chk($sformatf("init%0d_res_err", i), int'(bus.res_err),    0);
            @(negedge clk);
            #1;
        end
        bus.res_valid = 1'b0;
        bus.res_taken = 1'b0;
        if (expect_run) begin
            chk("run_busy",  int'(bus.busy),       0);
            chk("run_ready", int'(bus.pred_ready), 1);
            chk("run_occ",   int'(bus.occupancy),  0);
        end
    endtask

    initial begin
        // Segment A: pv pc rv rt | pred misp ready occ err
        add(0,3,0,0, 0,0,1,0,0);
        add(1,5,0,0, 0,0,1,0,0);
        add(1,5,1,0, 0,0,1,1,0);
        add(1,5,1,0, 0,0,1,1,0);
        add(1,5,1,0, 0,0,1,1,0);
        add(0,5,1,0, 0,0,1,1,0);
        add(0,5,0,0, 0,0,1,0,0);
        add(1,0,0,0, 0,0,1,0,0);
        add(0,0,1,1, 0,1,1,1,0);
        add(1,0,0,0, 0,0,1,0,0);
        add(0,0,1,1, 0,1,1,1,0);
        add(1,0,0,0, 0,0,1,0,0);
        add(0,0,1,1, 0,1,1,1,0);
        add(1,0,0,0, 0,0,1,0,0);
        add(0,0,1,1, 0,1,1,1,0);
        add(1,0,0,0, 0,0,1,0,0);
        add(0,0,1,1, 0,1,1,1,0);
        add(1,0,0,0, 0,0,1,0,0);
        add(0,0,1,1, 0,1,1,1,0);
        add(1,0,0,0, 1,0,1,0,0);
        add(0,0,1,1, 1,0,1,1,0);
        add(1,0,0,0, 1,0,1,0,0);
        add(0,0,1,1, 1,0,1,1,0);
        add(1,0,0,0, 1,0,1,0,0);
        add(0,0,1,1, 1,0,1,1,0);
        add(0,0,0,0, 1,0,1,0,0);
        add(1,0,0,0, 1,0,1,0,0);
        add(1,0,0,0, 1,0,1,1,0);
        add(1,0,0,0, 1,0,1,2,0);
        add(1,0,0,0, 1,0,1,3,0);
        add(1,0,0,0, 1,0,0,4,0);
        add(1,0,1,1, 1,0,0,4,0);
        add(0,0,0,0, 1,0,1,3,0);
        add(0,0,1,1, 1,0,1,3,0);
        add(0,0,1,1, 1,0,1,2,0);
        add(0,0,1,1, 1,0,1,1,0);
        add(0,0,1,1, 1,0,1,0,0);
        add(0,0,0,0, 1,0,1,0,1);
        add(0,0,0,0, 1,0,1,0,0);
        add(1,0,0,0, 1,0,1,0,0);
        seg_b = vecs.size();
        // Segment B, after re-INIT: mispredict flush and history repair
        add(1,1,0,0, 0,0,1,0,0);
        add(1,2,0,0, 0,0,1,1,0);
        add(1,3,0,0, 0,0,1,2,0);
        add(1,4,1,1, 0,1,1,3,0);
        add(0,0,0,0, 0,0,1,0,0);
        add(1,0,0,0, 0,0,1,0,0);
        add(0,0,1,1, 0,1,1,1,0);
        add(0,2,0,0, 1,0,1,0,0);

        bus.pred_valid = 1'b0;
        bus.pred_pc    = '0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",    int'(bus.busy),       1);
        chk("rst_ready",   int'(bus.pred_ready), 0);
        chk("rst_occ",     int'(bus.occupancy),  0);
        chk("rst_res_err", int'(bus.res_err),    0);
        reset = 1'b0;
        init_run(16, 1'b1);

        run_vecs(0, seg_b - 1);

        // Async reset with one branch in flight, then again at INIT cycle 7.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy",  int'(bus.busy),       1);
        chk("mid_rst_ready", int'(bus.pred_ready), 0);
        chk("mid_rst_occ",   int'(bus.occupancy),  0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        init_run(7, 1'b0);
        reset = 1'b1;
        #1;
        chk("init7_rst_busy", int'(bus.busy),       1);
        chk("init7_rst_occ",  int'(bus.occupancy),  0);
        #1;
        reset = 1'b0;
        init_run(16, 1'b1);

        run_vecs(seg_b, vecs.size() - 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
